// File: rtl/dcache_replace_arbiter_pkg.sv
// Shared cache command encoding, mirroring CacheTypes::CacheCommand used by the line replacer.
package dcache_replace_arbiter_pkg;

    localparam int unsigned CMD_W = 2;

    typedef enum logic [CMD_W-1:0] {
        CacheCommand_Invalidate   = 2'd0,
        CacheCommand_Replace      = 2'd1,
        CacheCommand_WriteThrough = 2'd2
    } CacheCommand;

endpackage

// File: rtl/dcache_replace_arbiter_round_robin_picker.sv
// Combinational round-robin picker: first asserted request at or after pointer, wrapping.
module dcache_replace_arbiter_round_robin_picker #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] request,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               found
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        grant    = '0;
        index    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand     = (32'(pointer) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && request[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                index           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/dcache_replace_arbiter.sv
// Round-robin arbiter sharing one D-cache line replacer: grant/latch, one-cycle enable, wait for done.
module dcache_replace_arbiter
    import dcache_replace_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned MEM_ADDR_WIDTH = 26
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                reqValid,
    input  logic [NUM_REQ*CMD_W-1:0]          reqCommand,
    input  logic [NUM_REQ*MEM_ADDR_WIDTH-1:0] reqAddr,
    output logic [NUM_REQ-1:0]                reqGrant,
    output logic [NUM_REQ-1:0]                reqDone,
    output logic                              busy,
    output logic                              replacerEnable,
    output CacheCommand                       replacerCommand,
    output logic [MEM_ADDR_WIDTH-1:0]         replacerAddr,
    input  logic                              replacerDone
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_t;

    arb_state_t                state, state_next;
    logic [IDX_W-1:0]          pointer, winner, pick_idx, ptr_next;
    logic [NUM_REQ-1:0]        pick_grant;
    logic                      pick_found;
    logic                      load, advance;
    CacheCommand               cmd_q, pick_cmd;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, pick_addr;

    dcache_replace_arbiter_round_robin_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .request (reqValid),
        .pointer (pointer),
        .grant   (pick_grant),
        .index   (pick_idx),
        .found   (pick_found)
    );

    assign pick_cmd  = CacheCommand'(reqCommand[pick_idx*CMD_W +: CMD_W]);
    assign pick_addr = reqAddr[pick_idx*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
    assign ptr_next  = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    always_comb begin
        state_next     = state;
        reqGrant       = '0;
        reqDone        = '0;
        replacerEnable = 1'b0;
        load           = 1'b0;
        advance        = 1'b0;
        case (state)
            ARB_IDLE: begin
                // Grant is gated by reset so every output reads 0 while rst is held low.
                if (pick_found && rst) begin
                    reqGrant   = pick_grant;
                    load       = 1'b1;
                    state_next = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                replacerEnable = 1'b1;
                state_next     = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (replacerDone) begin
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        reqDone[i] = (IDX_W'(i) == winner);
                    end
                    advance    = 1'b1;
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ARB_IDLE;
            pointer <= '0;
            winner  <= '0;
            cmd_q   <= CacheCommand_WriteThrough;
            addr_q  <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                winner <= pick_idx;
                cmd_q  <= pick_cmd;
                addr_q <= pick_addr;
            end
            if (advance) begin
                pointer <= ptr_next;
            end
        end
    end

    assign busy            = (state != ARB_IDLE);
    assign replacerCommand = cmd_q;
    assign replacerAddr    = addr_q;

endmodule

// File: tb/tb_dcache_replace_arbiter.sv
// Directed bench for dcache_replace_arbiter; grants and completions are matched against scoreboard queues.
module tb_dcache_replace_arbiter;
    import dcache_replace_arbiter_pkg::*;

    localparam int unsigned NR = 3;
    localparam int unsigned AW = 26;

    logic                 clk;
    logic                 rst;
    logic [NR-1:0]        reqValid;
    logic [NR*CMD_W-1:0]  reqCommand;
    logic [NR*AW-1:0]     reqAddr;
    logic [NR-1:0]        reqGrant;
    logic [NR-1:0]        reqDone;
    logic                 busy;
    logic                 replacerEnable;
    CacheCommand          replacerCommand;
    logic [AW-1:0]        replacerAddr;
    logic                 replacerDone;

    int errors = 0;
    int checks = 0;
    int exp_grant_q[$];
    int exp_done_q[$];

    dcache_replace_arbiter #(
        .NUM_REQ        (NR),
        .MEM_ADDR_WIDTH (AW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .reqValid        (reqValid),
        .reqCommand      (reqCommand),
        .reqAddr         (reqAddr),
        .reqGrant        (reqGrant),
        .reqDone         (reqDone),
        .busy            (busy),
        .replacerEnable  (replacerEnable),
        .replacerCommand (replacerCommand),
        .replacerAddr    (replacerAddr),
        .replacerDone    (replacerDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input CacheCommand c, input logic [AW-1:0] a);
        reqValid[i]               = v;
        reqCommand[i*CMD_W +: CMD_W] = c;
        reqAddr[i*AW +: AW]       = a;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, 64'(reqGrant), 64'(0));
        check({tag, "_done"},  64'(reqDone), 64'(0));
        check({tag, "_busy"},  64'(busy), 64'(0));
        check({tag, "_en"},    64'(replacerEnable), 64'(0));
        check({tag, "_cmd"},   64'(replacerCommand), 64'(CacheCommand_WriteThrough));
        check({tag, "_addr"},  64'(replacerAddr), 64'(0));
    endtask

    // Scoreboard: each observed grant pops its expected index and queues the matching completion.
    always @(negedge clk) begin
        int e;
        if (reqGrant !== '0) begin
            if (exp_grant_q.size() == 0) begin
                check("unexpected_grant", 64'(reqGrant), 64'(0));
            end else begin
                e = exp_grant_q.pop_front();
                check("grant", 64'(reqGrant), 64'(1) << e);
                exp_done_q.push_back(e);
            end
        end
        if (reqDone !== '0) begin
            if (exp_done_q.size() == 0) begin
                check("unexpected_done", 64'(reqDone), 64'(0));
            end else begin
                e = exp_done_q.pop_front();
                check("done", 64'(reqDone), 64'(1) << e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        reqValid     = '0;
        reqCommand   = '0;
        reqAddr      = '0;
        replacerDone = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;

        // Single Invalidate on requester 1
        set_req(1, 1'b1, CacheCommand_Invalidate, 26'h123);
        exp_grant_q.push_back(1);
        @(negedge clk);
        check("t1_busy_t", 64'(busy), 64'(0));
        check("t1_en_t", 64'(replacerEnable), 64'(0));
        step();
        reqValid[1] = 1'b0;
        @(negedge clk);
        check("t1_en_t1", 64'(replacerEnable), 64'(1));
        check("t1_addr", 64'(replacerAddr), 64'(26'h123));
        check("t1_cmd", 64'(replacerCommand), 64'(CacheCommand_Invalidate));
        check("t1_busy_t1", 64'(busy), 64'(1));
        step();
        replacerDone = 1'b1;
        @(negedge clk);
        check("t1_en_t2", 64'(replacerEnable), 64'(0));
        step();
        replacerDone = 1'b0;
        @(negedge clk);
        check("t1_busy_t3", 64'(busy), 64'(0));
        check("t1_en_t3", 64'(replacerEnable), 64'(0));

        // All three requesters held: order 0,1,2,0 from a reset pointer
        step();
        rst = 1'b0;
        exp_done_q.delete();
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req(i, 1'b1, CacheCommand_Invalidate, 26'(32'h100 + i));
        end
        exp_grant_q.push_back(0);
        exp_grant_q.push_back(1);
        exp_grant_q.push_back(2);
        exp_grant_q.push_back(0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t2_busy_idle", 64'(busy), 64'(0));
            check("t2_en_idle", 64'(replacerEnable), 64'(0));
            step();
            @(negedge clk);
            check("t2_en_issue", 64'(replacerEnable), 64'(1));
            check("t2_addr", 64'(replacerAddr), 64'(32'h100 + (k % 3)));
            step();
            replacerDone = 1'b1;
            @(negedge clk);
            step();
            replacerDone = 1'b0;
            if (k == 3) reqValid = '0;
        end
        @(negedge clk);
        check("t2_quiet", 64'(busy), 64'(0));

        // Replace with slow memory; requester changes its inputs after the grant
        step();
        set_req(0, 1'b1, CacheCommand_Replace, 26'h2AB);
        exp_grant_q.push_back(0);
        @(negedge clk);
        step();
        set_req(0, 1'b0, CacheCommand_Invalidate, 26'h3FF);
        @(negedge clk);
        check("t3_en", 64'(replacerEnable), 64'(1));
        check("t3_addr_issue", 64'(replacerAddr), 64'(26'h2AB));
        check("t3_cmd_issue", 64'(replacerCommand), 64'(CacheCommand_Replace));
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            check("t3_addr_wait", 64'(replacerAddr), 64'(26'h2AB));
            check("t3_cmd_wait", 64'(replacerCommand), 64'(CacheCommand_Replace));
            check("t3_en_wait", 64'(replacerEnable), 64'(0));
            check("t3_busy_wait", 64'(busy), 64'(1));
        end
        step();
        replacerDone = 1'b1;
        @(negedge clk);
        check("t3_addr_done", 64'(replacerAddr), 64'(26'h2AB));
        step();
        replacerDone = 1'b0;

        // Spurious completions in Idle and Issue
        replacerDone = 1'b1;
        @(negedge clk);
        check("t4_idle_busy", 64'(busy), 64'(0));
        check("t4_idle_done", 64'(reqDone), 64'(0));
        step();
        replacerDone = 1'b0;
        @(negedge clk);
        check("t4_idle_busy2", 64'(busy), 64'(0));
        step();
        set_req(2, 1'b1, CacheCommand_WriteThrough, 26'h055);
        exp_grant_q.push_back(2);
        @(negedge clk);
        step();
        reqValid     = '0;
        replacerDone = 1'b1;
        @(negedge clk);
        check("t4_issue_done", 64'(reqDone), 64'(0));
        check("t4_issue_en", 64'(replacerEnable), 64'(1));
        step();
        replacerDone = 1'b0;
        @(negedge clk);
        check("t4_wait_busy", 64'(busy), 64'(1));
        check("t4_wait_en", 64'(replacerEnable), 64'(0));
        step();
        @(negedge clk);
        check("t4_wait_busy2", 64'(busy), 64'(1));
        step();
        replacerDone = 1'b1;
        @(negedge clk);
        step();
        replacerDone = 1'b0;

        // Reset in the middle of a WriteThrough wait
        set_req(1, 1'b1, CacheCommand_WriteThrough, 26'h0AA);
        exp_grant_q.push_back(1);
        @(negedge clk);
        step();
        reqValid = '0;
        step();
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("t5_abort");
        exp_done_q.delete();
        set_req(2, 1'b1, CacheCommand_Invalidate, 26'h1C0);
        exp_grant_q.push_back(2);
        #1;
        check("t5_held_grant", 64'(reqGrant), 64'(0));
        step();
        rst = 1'b1;
        @(negedge clk);
        check("t5_busy_release", 64'(busy), 64'(0));
        step();
        reqValid = '0;
        @(negedge clk);
        check("t5_en", 64'(replacerEnable), 64'(1));
        check("t5_addr", 64'(replacerAddr), 64'(26'h1C0));
        step();
        replacerDone = 1'b1;
        @(negedge clk);
        step();
        replacerDone = 1'b0;

        // Requester 0 withdraws while the arbiter is busy
        set_req(1, 1'b1, CacheCommand_Replace, 26'h0F0);
        exp_grant_q.push_back(1);
        @(negedge clk);
        step();
        reqValid = 3'b001;
        @(negedge clk);
        step();
        reqValid = '0;
        @(negedge clk);
        step();
        replacerDone = 1'b1;
        @(negedge clk);
        step();
        replacerDone = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t6_idle_busy", 64'(busy), 64'(0));
        end

        check("grant_q_empty", 64'(exp_grant_q.size()), 64'(0));
        check("done_q_empty", 64'(exp_done_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
